maj_tree_pipe: RTL and testbench
================================

// Module: maj_tree_pipe
// PURPOSE
//  Parametrised, pipelined majority-of-three (MAJ3) tree evaluator for the MIG regression flow.
//  Generalises the fixed 3-level combinational MAJ3 netlists to any DEPTH.
//  Adds a register per tree level, valid/ready flow control, programmable leaf polarity and
//  leaf constants, and a result counter.
//  Sits between the pattern source and the golden-output comparator in the regression harness.
// PARAMETERS
//  DEPTH    3   tree levels; LEAVES = 3**DEPTH (27 at default); DEPTH >= 1
//  COUNT_W  16  width of the po_count result counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  pi_valid     in   1       input vector valid
//  pi_ready     out  1       block can accept pi_data this cycle
//  pi_data      in   LEAVES  leaf values; bit i = leaf i
//  cfg_we       in   1       load the three cfg_* registers below
//  cfg_inv      in   LEAVES  per-leaf inversion mask
//  cfg_const_en in   LEAVES  per-leaf constant-override enable
//  cfg_const_v  in   LEAVES  per-leaf constant value
//  po_valid     out  1       result valid
//  po_ready     in   1       downstream accepts result
//  po0          out  1       tree output
//  po_count     out  COUNT_W completed output handshakes (saturating)
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the caller): all stage valid bits, stage data,
//    cfg registers and po_count clear to 0. Outputs: po_valid=0, po0=0, po_count=0.
//    pi_ready=1 one cycle after deassertion.
//  - Leaf value: leaf[i] = cfg_const_en[i] ? cfg_const_v[i] : (pi_data[i] ^ cfg_inv[i]).
//    Applied combinationally at input acceptance.
//  - Stages: stage k (1..DEPTH) holds 3**(DEPTH-k) bits plus one valid bit v[k].
//    Bit j of stage k = MAJ3(bits 3j, 3j+1, 3j+2 of stage k-1); stage 0 = leaves.
//    Stage DEPTH drives po0 and po_valid = v[DEPTH].
//  - Advance: adv[DEPTH] = !v[DEPTH] | po_ready; adv[k] = !v[k] | adv[k+1];
//    pi_ready = adv[1]. Combinational po_ready->pi_ready path is accepted.
//  - Transfers: input accepted when pi_valid & pi_ready.
//    On adv[k], stage k loads stage k-1 and v[k] <= v[k-1] (v[0] = pi_valid).
//    A stage that is not advancing holds data and valid unchanged.
//  - Latency and throughput: with no stall, a vector accepted in cycle t gives
//    po_valid=1 in cycle t+DEPTH. Throughput is 1 vector/cycle. Bubbles collapse.
//  - Ordering: strict FIFO order, no drop, no duplicate. po0 is stable while
//    po_valid & !po_ready.
//  - cfg_we: cfg registers update on the clock edge. The new values apply to vectors
//    accepted from the next cycle on. A vector accepted in the same cycle as cfg_we
//    uses the old values. In-flight vectors are unaffected.
//  - po_count: +1 per cycle with po_valid & po_ready; holds at 2**COUNT_W-1.
//  - Reset mid-operation: all in-flight vectors are discarded immediately;
//    po_valid drops asynchronously.
//  - pi_valid with pi_ready=0: no transfer. The source must hold pi_data until accepted.
// TESTING (DEPTH=3, COUNT_W=4 unless noted)
//  1. Reset, cfg=0, pi_data=27'h0 then 27'h7FFFFFF, po_ready=1
//     -> po0=0 in cycle t+3, po0=1 in cycle t+4, po_count=2.
//  2. pi_data=27'h0003FFF (leaves 0..13 set) -> po0=1.
//     Then cfg_inv=27'h7FFFFFF with the same data -> po0=0.
//  3. cfg_const_en=27'h7FFFFFF, cfg_const_v=27'h0, pi_data=27'h7FFFFFF -> po0=0.
//     cfg_we in the same cycle as acceptance -> that vector still uses the old cfg.
//  4. Stream 8 random vectors with po_ready toggling 1,0,0,1,...
//     -> results match a reference MAJ3-tree model, in order, none lost; pi_ready=0
//     only once all 3 stages are full and po_ready=0.
//  5. Complete 20 handshakes -> po_count saturates at 4'hF.
//     Assert rst_n low with 3 vectors in flight -> po_valid=0 immediately and no
//     stale output after release.
//  6. DEPTH=1 and DEPTH=4 builds: all-ones -> 1, all-zeros -> 0.
//     Latency equals DEPTH cycles.

Source files
------------

// File: rtl/maj_tree_pipe.sv
// Pipelined MAJ3 tree evaluator: one register stage per tree level with valid/ready
// flow control, per-leaf inversion/constant override and a saturating result counter.
module maj_tree_pipe #(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned COUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pi_valid,
    output logic                 pi_ready,
    input  logic [3**DEPTH-1:0]  pi_data,
    input  logic                 cfg_we,
    input  logic [3**DEPTH-1:0]  cfg_inv,
    input  logic [3**DEPTH-1:0]  cfg_const_en,
    input  logic [3**DEPTH-1:0]  cfg_const_v,
    output logic                 po_valid,
    input  logic                 po_ready,
    output logic                 po0,
    output logic [COUNT_W-1:0]   po_count
);

    localparam int unsigned LEAVES = 3**DEPTH;
    // Stages 1..DEPTH are packed back to back, stage 1 at bit 0, stage DEPTH at the top bit.
    localparam int unsigned RW     = (LEAVES - 1) / 2;

    logic [LEAVES-1:0] inv_q;
    logic [LEAVES-1:0] cen_q;
    logic [LEAVES-1:0] cv_q;
    logic [LEAVES-1:0] leaf;

    logic [RW-1:0]     sd;
    logic [RW-1:0]     sd_nxt;
    logic [RW-1:0]     sd_en;

    logic [DEPTH:1]    v;
    logic [DEPTH:1]    adv;
    logic [DEPTH:0]    vin;

    function automatic logic maj3(input logic [2:0] x);
        return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
    endfunction

    always_comb leaf = (cen_q & cv_q) | (~cen_q & (pi_data ^ inv_q));

    always_comb begin
        adv        = '0;
        adv[DEPTH] = !v[DEPTH] | po_ready;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            adv[DEPTH-i] = !v[DEPTH-i] | adv[DEPTH-i+1];
        end
    end

    assign pi_ready = adv[1];
    assign vin      = {v, pi_valid};
    assign po_valid = v[DEPTH];
    assign po0      = sd[RW-1];

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        localparam int unsigned W   = 3**(DEPTH-k);
        localparam int unsigned OFF = (LEAVES - 3*W) / 2;
        for (genvar j = 0; j < W; j++) begin : g_bit
            if (k == 1) begin : g_leaf
                assign sd_nxt[OFF+j] = maj3(leaf[3*j +: 3]);
            end else begin : g_inner
                localparam int unsigned POFF = (LEAVES - 9*W) / 2;
                assign sd_nxt[OFF+j] = maj3(sd[POFF+3*j +: 3]);
            end
            assign sd_en[OFF+j] = adv[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v  <= '0;
            sd <= '0;
        end else begin
            v  <= (v & ~adv) | (vin[DEPTH-1:0] & adv);
            sd <= (sd & ~sd_en) | (sd_nxt & sd_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= '0;
            cen_q <= '0;
            cv_q  <= '0;
        end else if (cfg_we) begin
            inv_q <= cfg_inv;
            cen_q <= cfg_const_en;
            cv_q  <= cfg_const_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            po_count <= '0;
        end else if (po_valid && po_ready && po_count != '1) begin
            po_count <= po_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_maj_tree_pipe.sv
// Bench for maj_tree_pipe: DEPTH=3 main instance checked every cycle against a queue model,
// plus DEPTH=1 and DEPTH=4 instances for latency/extreme-value checks.
module tb_maj_tree_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pi_valid, pi_ready, cfg_we, po_valid, po_ready, po0;
    logic [26:0] pi_data, cfg_inv, cfg_const_en, cfg_const_v;
    logic [3:0]  po_count;

    logic        a_valid, a_ready, a_po_valid, a_po0;
    logic [2:0]  a_data, a_zero;
    logic [3:0]  a_count;
    logic        b_valid, b_ready, b_po_valid, b_po0;
    logic [80:0] b_data, b_zero;
    logic [3:0]  b_count;
    logic        cfg_off = 1'b0;
    logic        side_ready = 1'b1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    maj_tree_pipe #(.DEPTH(3), .COUNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .pi_valid(pi_valid), .pi_ready(pi_ready), .pi_data(pi_data),
        .cfg_we(cfg_we), .cfg_inv(cfg_inv), .cfg_const_en(cfg_const_en), .cfg_const_v(cfg_const_v),
        .po_valid(po_valid), .po_ready(po_ready), .po0(po0), .po_count(po_count));

    maj_tree_pipe #(.DEPTH(1), .COUNT_W(4)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .pi_valid(a_valid), .pi_ready(a_ready), .pi_data(a_data),
        .cfg_we(cfg_off), .cfg_inv(a_zero), .cfg_const_en(a_zero), .cfg_const_v(a_zero),
        .po_valid(a_po_valid), .po_ready(side_ready), .po0(a_po0), .po_count(a_count));

    maj_tree_pipe #(.DEPTH(4), .COUNT_W(4)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .pi_valid(b_valid), .pi_ready(b_ready), .pi_data(b_data),
        .cfg_we(cfg_off), .cfg_inv(b_zero), .cfg_const_en(b_zero), .cfg_const_v(b_zero),
        .po_valid(b_po_valid), .po_ready(side_ready), .po0(b_po0), .po_count(b_count));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: apply leaf rules, then repeatedly collapse triples by vote count.
    function automatic bit model_out(input logic [26:0] d, input logic [26:0] inv,
                                     input logic [26:0] en, input logic [26:0] cv);
        int a[27];
        int n;
        for (int i = 0; i < 27; i++) a[i] = en[i] ? int'(cv[i]) : int'(d[i] ^ inv[i]);
        n = 27;
        while (n > 1) begin
            for (int j = 0; j < n / 3; j++) begin
                a[j] = (a[3*j] + a[3*j+1] + a[3*j+2] >= 2) ? 1 : 0;
            end
            n = n / 3;
        end
        return a[0] != 0;
    endfunction

    // Scoreboard: each accepted vector carries its result and acceptance cycle; the head
    // reaches the output DEPTH cycles after acceptance since nothing ahead of it can block.
    logic [26:0]  m_inv, m_cen, m_cv;
    bit           q_res[$];
    int unsigned  q_t[$];
    int unsigned  cyc = 0;
    int unsigned  mcount = 0;
    int unsigned  popped = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : monitor
        bit ev, er;
        if (!rst_n) begin
            q_res.delete();
            q_t.delete();
            mcount = 0;
            m_inv  = '0;
            m_cen  = '0;
            m_cv   = '0;
            chk("mon_rst_po_valid", {31'b0, po_valid}, 0);
            chk("mon_rst_po_count", {28'b0, po_count}, 0);
        end else begin
            ev = (q_res.size() != 0) && (cyc - q_t[0] >= 3);
            er = !(q_res.size() == 3 && !po_ready);
            chk("mon_po_valid", {31'b0, po_valid}, {31'b0, ev});
            chk("mon_pi_ready", {31'b0, pi_ready}, {31'b0, er});
            chk("mon_po_count", {28'b0, po_count}, mcount);
            if (ev) chk("mon_po0", {31'b0, po0}, {31'b0, q_res[0]});
            if (ev && po_ready) begin
                void'(q_res.pop_front());
                void'(q_t.pop_front());
                popped++;
                if (mcount < 15) mcount++;
            end
            if (pi_valid && er) begin
                q_res.push_back(model_out(pi_data, m_inv, m_cen, m_cv));
                q_t.push_back(cyc);
            end
            if (cfg_we) begin
                m_inv = cfg_inv;
                m_cen = cfg_const_en;
                m_cv  = cfg_const_v;
            end
        end
    end

    task automatic set_cfg(input logic [26:0] inv, input logic [26:0] en, input logic [26:0] cv);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_inv = inv; cfg_const_en = en; cfg_const_v = cv;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic send_one(input logic [26:0] d, input logic e, input string nm);
        int unsigned n;
        bit seen;
        @(posedge clk); #1;
        pi_valid = 1'b1; pi_data = d;
        @(negedge clk);
        chk({nm, "_ready"}, {31'b0, pi_ready}, 1);
        @(posedge clk); #1;
        pi_valid = 1'b0;
        seen = 1'b0;
        n = 1;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (po_valid) seen = 1'b1;
            else n++;
        end
        chk({nm, "_latency"}, n, 3);
        chk({nm, "_po0"}, {31'b0, po0}, {31'b0, e});
    endtask

    logic [26:0] vecs [8] = '{27'h5A3C1F2, 27'h1234567, 27'h7ABCDEF, 27'h0F0F0F0,
                              27'h3333333, 27'h6DB6DB6, 27'h0000FFF, 27'h7FF8000};

    initial begin
        int unsigned i, c, p0, la, lb;
        rst_n = 1'b0; pi_valid = 1'b0; pi_data = '0; cfg_we = 1'b0;
        cfg_inv = '0; cfg_const_en = '0; cfg_const_v = '0; po_ready = 1'b1;
        a_valid = 1'b0; a_data = '0; a_zero = '0;
        b_valid = 1'b0; b_data = '0; b_zero = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_po_valid", {31'b0, po_valid}, 0);
        chk("rst_po0", {31'b0, po0}, 0);
        chk("rst_po_count", {28'b0, po_count}, 0);
        chk("rst_pi_ready", {31'b0, pi_ready}, 1);

        // 1: zeros then ones back to back
        @(posedge clk); #1; pi_valid = 1'b1; pi_data = '0;
        @(posedge clk); #1; pi_data = '1;
        @(posedge clk); #1; pi_valid = 1'b0; pi_data = '0;
        @(negedge clk); chk("t1_t2_po_valid", {31'b0, po_valid}, 0);
        @(negedge clk); chk("t1_t3_po_valid", {31'b0, po_valid}, 1);
        chk("t1_t3_po0", {31'b0, po0}, 0);
        @(negedge clk); chk("t1_t4_po_valid", {31'b0, po_valid}, 1);
        chk("t1_t4_po0", {31'b0, po0}, 1);
        @(negedge clk); chk("t1_po_count", {28'b0, po_count}, 2);

        // 2: leaves 0..13 set, then the same data fully inverted
        send_one(27'h0003FFF, 1'b1, "t2_plain");
        set_cfg('1, '0, '0);
        send_one(27'h0003FFF, 1'b0, "t2_inv");

        // 3: constant override, with the cfg write landing on the acceptance cycle
        set_cfg('0, '0, '0);
        @(posedge clk); #1;
        pi_valid = 1'b1; pi_data = '1;
        cfg_we = 1'b1; cfg_inv = '0; cfg_const_en = '1; cfg_const_v = '0;
        @(posedge clk); #1; cfg_we = 1'b0;
        @(posedge clk); #1; pi_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("t3_old_cfg_po0", {31'b0, po0}, 1);
        @(negedge clk); chk("t3_new_cfg_po0", {31'b0, po0}, 0);
        send_one(27'h7FFFFFF, 1'b0, "t3_const");

        // 4: stream under a 1,0,0 po_ready pattern with mixed leaf config
        set_cfg(27'h2492492, 27'h0000700, 27'h0000500);
        p0 = popped; i = 0; c = 0;
        while ((i < 8 || popped < p0 + 8) && c < 200) begin
            @(posedge clk); #1;
            po_ready = (c % 3 == 0);
            if (i < 8) begin pi_valid = 1'b1; pi_data = vecs[i]; end
            else pi_valid = 1'b0;
            @(negedge clk);
            if (pi_valid && pi_ready) i++;
            c++;
        end
        chk("t4_results_out", popped - p0, 8);
        @(posedge clk); #1; pi_valid = 1'b0; po_ready = 1'b1;
        set_cfg('0, '0, '0);

        // 5: saturate the counter, then reset with three vectors in flight
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1; pi_valid = 1'b1; pi_data = 27'(k * 27'h0123457);
        end
        @(posedge clk); #1; pi_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_count_sat", {28'b0, po_count}, 32'hF);
        @(posedge clk); #1; po_ready = 1'b0; pi_valid = 1'b1; pi_data = '1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1; pi_valid = 1'b0;
        chk("t5_full_po_valid", {31'b0, po_valid}, 1);
        #1 rst_n = 1'b0;
        #1 chk("t5_async_po_valid", {31'b0, po_valid}, 0);
        chk("t5_async_po_count", {28'b0, po_count}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; po_ready = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("t5_no_stale", {31'b0, po_valid}, 0);
        end

        // 6: DEPTH=1 and DEPTH=4 builds, extreme inputs and latency
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk); #1;
            a_valid = 1'b1; a_data = (pass != 0) ? '1 : '0;
            b_valid = 1'b1; b_data = (pass != 0) ? '1 : '0;
            @(negedge clk);
            chk("t6_d1_ready", {31'b0, a_ready}, 1);
            chk("t6_d4_ready", {31'b0, b_ready}, 1);
            @(posedge clk); #1; a_valid = 1'b0; b_valid = 1'b0;
            la = 0; lb = 0;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (a_po_valid && la == 0) begin
                    la = n;
                    chk("t6_d1_po0", {31'b0, a_po0}, pass);
                end
                if (b_po_valid && lb == 0) begin
                    lb = n;
                    chk("t6_d4_po0", {31'b0, b_po0}, pass);
                end
            end
            chk("t6_d1_latency", la, 1);
            chk("t6_d4_latency", lb, 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
